// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   - uart_rx_state_t : receiver FSM state encoding
//   - UART_OVERSAMPLE : oversample ratio, shared with the baud generator divider
//   - uart_parity()   : XOR parity over the low nbits of a word, reused by the transmitter
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_MAX_BITS   = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  // Even parity of data[nbits-1:0]; inverted for odd parity.
  function automatic logic uart_parity(input logic [UART_MAX_BITS-1:0] data,
                                       input int unsigned nbits,
                                       input logic odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < UART_MAX_BITS; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, flops load RST_VAL
//   d_i  - asynchronous input
//   q_o  - synchronised output (2 clk latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-entry valid/ready holding register.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   rx_tick      - oversample square wave; each rising edge is one sample instant
//   rx           - asynchronous serial line, idle high
//   out_data     - received word, LSB first on the wire
//   out_valid    - holding register full; out_ready accepts it
//   busy         - frame in progress
//   frame_err    - pulse: stop bit sampled low
//   parity_err   - pulse: parity mismatch
//   overrun_err  - pulse: frame completed while the holding register was full
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_rx_state_t       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 armed_q;
  logic                 rx_tick_d_q;
  logic [DATA_BITS-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_err_q;

  logic rx_s;
  logic tick_en_c;
  logic cnt_last_c;
  logic hold_free_c;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign tick_en_c   = rx_tick & ~rx_tick_d_q;
  assign cnt_last_c  = (cnt_q == CNT_LAST);
  // A simultaneous accept frees the register for a same-cycle load.
  assign hold_free_c = ~out_valid_q | out_ready;

  // Receiver FSM, counters, shift register and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      armed_q       <= 1'b0;
      rx_tick_d_q   <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_tick_d_q   <= rx_tick;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;

      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (tick_en_c) begin
        // Arming only after seeing the line high keeps a low-held line from looking like a start.
        if (rx_s) armed_q <= 1'b1;

        case (state_q)
          IDLE: begin
            if (armed_q && !rx_s) begin
              state_q   <= START;
              cnt_q     <= '0;
              par_err_q <= 1'b0;
              busy_q    <= 1'b1;
            end
          end

          START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              if (!rx_s) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          DATA: begin
            if (cnt_last_c) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              cnt_q   <= '0;
              if (bit_idx_q == BIT_LAST) begin
                bit_idx_q <= '0;
                state_q   <= PARITY_EN ? PARITY : STOP;
              end else begin
                bit_idx_q <= bit_idx_q + BIT_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          PARITY: begin
            if (cnt_last_c) begin
              par_err_q <= (rx_s != uart_parity(UART_MAX_BITS'(shift_q), DATA_BITS, PARITY_ODD));
              cnt_q     <= '0;
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          STOP: begin
            if (cnt_last_c) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (!rx_s) begin
                frame_err_q <= 1'b1;
              end else if (par_err_q) begin
                parity_err_q <= 1'b1;
              end else if (hold_free_c) begin
                out_data_q  <= shift_q;
                out_valid_q <= 1'b1;
              end else begin
                overrun_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

- 16x-oversampling UART receiver.
- Recovers 8N1-style frames (optional parity) from the asynchronous `rx` pin, timed by the oversample clock from the baud-rate generator, and presents each byte through a one-entry valid/ready holding register.
- Sits directly downstream of the baud-rate generator's `RX_tick` output, alongside the UART transmitter.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `OVERSAMPLE`, 16: `rx_tick` rising edges per bit; must be even, ≥ 8.
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN` = 0.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `rx_tick` in 1: square wave from the baud generator, `clk` domain; each rising edge is one oversample instant.
- `rx` in 1: serial line, asynchronous, idle high.
- `out_data` out `DATA_BITS`: received word, LSB = first bit on the wire.
- `out_valid` out 1: holding register full; held until accepted.
- `out_ready` in 1: consumer accepts; a transfer occurs when `out_valid` & `out_ready`.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `frame_err` out 1: one-cycle pulse, stop bit sampled 0.
- `parity_err` out 1: one-cycle pulse, parity mismatch.
- `overrun_err` out 1: one-cycle pulse, frame completed while the holding register was full.

## Operation
- **rx synchroniser:** `rx` passes through a 2-flop synchroniser, reset value 1, giving `rx_s`.
- **Tick enable:** `tick_en` = `rx_tick` & ~`rx_tick_d`. `rx_tick_d` resets to 0. All FSM activity is qualified by `tick_en`.
- **armed flag:**
  - Cleared by reset; set on any `tick_en` with `rx_s` = 1.
  - Start detection requires `armed`. A line held low through reset is therefore never mistaken for a start bit.
- **IDLE:** on `tick_en` & `armed` & `rx_s` = 0, go to START with `cnt` = 0.
- **START:**
  - On each `tick_en`: if `cnt` = `OVERSAMPLE`/2−1, test `rx_s`.
    - `rx_s` = 0: go to DATA with `cnt` = 0 and `bit_idx` = 0.
    - `rx_s` = 1: false start (glitch); go to IDLE silently.
  - Otherwise `cnt`++.
- **DATA:**
  - On `tick_en` with `cnt` = `OVERSAMPLE`−1: shift `rx_s` into the shift register LSB-first, `cnt` = 0, `bit_idx`++.
  - After bit `DATA_BITS`−1, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** sample at `cnt` = `OVERSAMPLE`−1. Compare against the XOR of the data bits (inverted when `PARITY_ODD`). Store the mismatch flag. Go to STOP.
- **STOP:** sample at `cnt` = `OVERSAMPLE`−1, then always go to IDLE (mid-stop-bit). The outcome is resolved in this priority:
  1. `rx_s` = 0: `frame_err` pulse; data discarded.
  2. Parity mismatch stored: `parity_err` pulse; data discarded.
  3. Holding register free: load `out_data`, set `out_valid`. The register counts as free when `out_valid` = 0, or when `out_valid` & `out_ready` in the same cycle (simultaneous accept and load is legal).
  4. Holding register full, no accept this cycle: `overrun_err` pulse; new word dropped, old word kept.
- **Consumer handshake:** `out_valid` clears on `out_valid` & `out_ready` unless a load happens in the same cycle.
- **Frame error with line still low (break):** after returning to IDLE, `armed` remains set and `rx_s` is 0, so a new START begins on the next `tick_en`.

## Timing
- **Reset values:** `out_data` = 0, `out_valid` = 0, `busy` = 0, all error pulses 0. State = IDLE, `cnt` = 0, `bit_idx` = 0, `armed` = 0.
- **Reset mid-frame:** partial word discarded; `out_valid` cleared; the next start requires re-arming.
- **Sampling points:** let T0 be the `tick_en` on which the start bit is detected.
  - Start-bit check at T0+`OVERSAMPLE`/2.
  - Data bit n sampled at T0+`OVERSAMPLE`/2+`OVERSAMPLE`·(n+1).
  - Stop bit sampled at T0+`OVERSAMPLE`/2+`OVERSAMPLE`·(`DATA_BITS`+1+`PARITY_EN`).
- **Output update:** `out_valid`, error pulses and `busy` falling are all registered. They change on the clock edge that ends the stop-sample `tick_en` cycle.
- **Latency:** `rx` pin to `rx_s` is 2 clk. Detection jitter is up to one tick period.
- **Idle handshake path:** `out_ready` → `out_valid` low takes 1 clk. There is no combinational path from `out_ready` to any output.
- **Counter widths:** `cnt` is clog2(`OVERSAMPLE`) bits; `bit_idx` is clog2(`DATA_BITS`+1) bits. Neither wraps, because both are reset explicitly at every state transition.

## Structure
- **Shared package `uart_pkg`:**
  - `uart_rx_state_t` enum {IDLE, START, DATA, PARITY, STOP}.
  - `UART_OVERSAMPLE` = 16 constant, shared with the baud generator's divide ratio.
  - Parity helper function, reused by the transmitter.
- **Sub-module `uart_sync2`:** 2-flop synchroniser with a reset-value parameter.
- **Top level:** the FSM, counters, shift register and holding register stay in `uart_rx`.

## Test plan
Bench drives `rx_tick` toggling every 4 clk (8-clk tick period, 128 clk per bit).
- **Nominal byte:** 8N1 frame 0xA5 with `out_ready` held high → `out_data` = 0xA5 and `out_valid` high one cycle after the stop sample; no error pulses.
- **Glitch:** low pulse of 3 ticks on idle `rx` → START aborts at the mid-start check; `busy` returns to 0; `out_valid` never asserts.
- **Frame error:** stop bit driven 0 for frame 0x3C → `frame_err` pulse; `out_valid` stays 0; the following valid frame 0x81 is received correctly.
- **Parity error:** with `PARITY_EN` = 1, even parity, send 0x07 with parity bit 0 → `parity_err` pulse, no data delivered. With parity bit 1 → 0x07 delivered.
- **Overrun and back-pressure:** `out_ready` = 0, send 0x11 then 0x22 → `out_valid` holds 0x11 and `overrun_err` pulses at the second stop sample. Raising `out_ready` then releases 0x11.
- **Reset mid-frame:** assert `rst` during bit 3 while `rx` = 0 → outputs return to reset values and no start is detected until `rx` has been high for one tick. The next frame 0x5A is received.
